cpu_run_ctrl: RTL

- Run/halt/step controller that sequences the CPU core. Replaces the free-running clock divider with a single-clock-domain clock-enable tick.
- Accepts host commands: run, halt, single-step.
- Stops the core on a PC breakpoint.
- Snapshots general-purpose register x3 while the core is halted, so the board-level top can display it.
- Sits between the top level and cpu_top; cpu_top advances only on cycles where cpu_en=1.

---
 rtl/cpu_run_ctrl_if.sv | 24 ++
 rtl/cpu_run_ctrl.sv | 130 +++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl_if.sv
// Host command channel of the run/halt/step controller.
// The host drives commands and the controller answers with cmd_ready.
interface cpu_run_ctrl_if #(
    parameter int DIV_W = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [DIV_W-1:0] div_val;

    modport master (
        output cmd_valid,
        output cmd_op,
        output div_val,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  div_val,
        output cmd_ready
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run/halt/step sequencer for the CPU core: issues a one-cycle cpu_en tick every
// div_reg+1 cycles, stops on a PC breakpoint and snapshots x3 while halted.
module cpu_run_ctrl #(
    parameter int DIV_W  = 16,
    parameter int PC_W   = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    cpu_run_ctrl_if.slave     cmd,
    input  logic              bp_en,
    input  logic [PC_W-1:0]   bp_addr,
    input  logic [PC_W-1:0]   pc,
    input  logic [DATA_W-1:0] x3_in,
    output logic              cpu_en,
    output logic              halted,
    output logic              bp_hit,
    output logic [CNT_W-1:0]  step_count,
    output logic [DATA_W-1:0] x3_snap
);

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } state_t;

    localparam logic [1:0] OP_RUN  = 2'b01;
    localparam logic [1:0] OP_HALT = 2'b10;
    localparam logic [1:0] OP_STEP = 2'b11;

    state_t           state;
    logic [DIV_W-1:0] div_reg;
    logic [DIV_W-1:0] cnt;
    logic             skip_bp;
    logic             cmd_ready_q;

    logic             cmd_accept;
    logic             bp_stop;
    logic             active;
    logic             tick;

    // Breakpoint is only armed in RUN, and skip_bp lets a run resumed on the
    // breakpoint PC execute that instruction once.
    assign cmd_accept = cmd.cmd_valid && cmd_ready_q;
    assign bp_stop    = (state == ST_RUN) && bp_en && (pc == bp_addr) && !skip_bp;
    assign active     = (state == ST_RUN) || (state == ST_STEP);
    assign tick       = active && (cnt == div_reg) && !bp_stop;

    assign cpu_en        = tick;
    assign cmd.cmd_ready = cmd_ready_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_HALT;
            div_reg     <= '0;
            cnt         <= '0;
            skip_bp     <= 1'b0;
            step_count  <= '0;
            bp_hit      <= 1'b0;
            x3_snap     <= '0;
            cmd_ready_q <= 1'b1;
            halted      <= 1'b1;
        end else begin
            if (state == ST_HALT) begin
                x3_snap <= x3_in;
            end

            if (tick) begin
                step_count <= step_count + CNT_W'(1);
            end

            case (state)
                ST_HALT: begin
                    if (cmd_accept && cmd.cmd_op == OP_RUN) begin
                        div_reg     <= cmd.div_val;
                        cnt         <= '0;
                        skip_bp     <= 1'b1;
                        bp_hit      <= 1'b0;
                        state       <= ST_RUN;
                        halted      <= 1'b0;
                        cmd_ready_q <= 1'b1;
                    end else if (cmd_accept && cmd.cmd_op == OP_STEP) begin
                        div_reg     <= cmd.div_val;
                        cnt         <= '0;
                        bp_hit      <= 1'b0;
                        state       <= ST_STEP;
                        halted      <= 1'b0;
                        cmd_ready_q <= 1'b0;
                    end
                end

                ST_RUN: begin
                    cnt <= tick ? '0 : cnt + DIV_W'(1);
                    if (tick) begin
                        skip_bp <= 1'b0;
                    end
                    // A breakpoint wins over a simultaneous halt so bp_hit still reports it.
                    if (bp_stop) begin
                        bp_hit      <= 1'b1;
                        state       <= ST_HALT;
                        halted      <= 1'b1;
                        cmd_ready_q <= 1'b1;
                    end else if (cmd_accept && cmd.cmd_op == OP_HALT) begin
                        state       <= ST_HALT;
                        halted      <= 1'b1;
                        cmd_ready_q <= 1'b1;
                    end
                end

                ST_STEP: begin
                    cnt <= tick ? '0 : cnt + DIV_W'(1);
                    if (tick) begin
                        state       <= ST_HALT;
                        halted      <= 1'b1;
                        cmd_ready_q <= 1'b1;
                    end
                end

                default: begin
                    state       <= ST_HALT;
                    halted      <= 1'b1;
                    cmd_ready_q <= 1'b1;
                end
            endcase
        end
    end

endmodule
